// File: rtl/counter_monitor_pkg.sv
// Shared types and helpers for the mod-N counter sequence monitor.
package counter_monitor_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Value a healthy mod-n counter shows one sample after prev.
  function automatic logic [CODE_W-1:0] next_count(input logic [CODE_W-1:0] prev,
                                                   input int unsigned       n);
    if (prev == CODE_W'(n - 1)) return '0;
    return prev + CODE_W'(1);
  endfunction

endpackage

// File: rtl/counter_monitor_decode.sv
// Combinational decode of the observed 3-bit code into one-hot[N] plus range flag.
module counter_monitor_decode
  import counter_monitor_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [CODE_W-1:0] v,
  output logic [N-1:0]      onehot,
  output logic              in_range
);

  always_comb begin
    in_range = (int'(v) < N);
    for (int i = 0; i < N; i++) begin
      onehot[i] = (int'(v) == i);
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Sequence checker for a mod-N counter: lock/err/wrap flags, one-hot decode.
// Optional saturating error counter enabled by COUNTER_MONITOR_ERRCNT_EN.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int N        = 5,
  parameter int LOCK_CNT = 2,
  parameter int ERRW     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Q0,
  input  logic            Q1,
  input  logic            Q2,
  output logic            locked,
  output logic            err,
  output logic            wrap,
  output logic [N-1:0]    onehot,
  output logic [ERRW-1:0] err_count
);

  logic [CODE_W-1:0] v;
  logic [N-1:0]      dec_onehot;
  logic              in_range;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] prev_q;
  logic [3:0]        gcnt_q, gcnt_d, gcnt_inc;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;
  logic [N-1:0]      onehot_q;
  logic              good, is_zero;

  assign v = {Q2, Q1, Q0};

  counter_monitor_decode #(.N(N)) u_decode (
    .v        (v),
    .onehot   (dec_onehot),
    .in_range (in_range)
  );

  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    err_d    = 1'b0;
    wrap_d   = 1'b0;
    good     = (v == next_count(prev_q, N));
    is_zero  = (v == '0);
    gcnt_inc = gcnt_q + 4'd1;

    // Out-of-range codes override any step judgement.
    if (!in_range) begin
      err_d   = 1'b1;
      state_d = SEARCH;
      gcnt_d  = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (is_zero) begin
            state_d = ACQUIRE;
            gcnt_d  = '0;
          end
        end
        ACQUIRE: begin
          if (good) begin
            gcnt_d = gcnt_inc;
            if (gcnt_inc == 4'(LOCK_CNT)) state_d = LOCKED;
          end else if (is_zero) begin
            gcnt_d = '0;
          end else begin
            state_d = SEARCH;
            gcnt_d  = '0;
          end
        end
        LOCKED: begin
          // A good step landing on 0 can only be the N-1 -> 0 wrap.
          if (good) begin
            wrap_d = is_zero;
          end else begin
            err_d   = 1'b1;
            state_d = SEARCH;
            gcnt_d  = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          gcnt_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      gcnt_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= v;
      gcnt_q   <= gcnt_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      onehot_q <= dec_onehot;
    end
  end

  assign locked = locked_q;
  assign err    = err_q;
  assign wrap   = wrap_q;
  assign onehot = onehot_q;

`ifdef COUNTER_MONITOR_ERRCNT_EN
  logic [ERRW-1:0] errcnt_q, errcnt_d;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
    if (&c) return c;
    return c + ERRW'(1);
  endfunction

  assign errcnt_d = err_d ? sat_inc(errcnt_q) : errcnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) errcnt_q <= '0;
    else       errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_counter_monitor.sv
// Randomised + directed bench for counter_monitor against a run-length model.
module tb_counter_monitor;

  localparam int N  = 5;
  localparam int LC = 2;
`ifdef COUNTER_MONITOR_ERRCNT_EN
  localparam int ECNT_ON = 1;
`else
  localparam int ECNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic q0 = 1'b0, q1 = 1'b0, q2 = 1'b0;

  logic         a_locked, a_err, a_wrap;
  logic [N-1:0] a_onehot;
  logic [7:0]   a_cnt;
  logic         b_locked, b_err, b_wrap;
  logic [N-1:0] b_onehot;
  logic [1:0]   b_cnt;

  counter_monitor #(.N(N), .LOCK_CNT(LC), .ERRW(8)) dut_a (
    .clk(clk), .reset(reset), .Q0(q0), .Q1(q1), .Q2(q2),
    .locked(a_locked), .err(a_err), .wrap(a_wrap),
    .onehot(a_onehot), .err_count(a_cnt)
  );

  counter_monitor #(.N(N), .LOCK_CNT(LC), .ERRW(2)) dut_b (
    .clk(clk), .reset(reset), .Q0(q0), .Q1(q1), .Q2(q2),
    .locked(b_locked), .err(b_err), .wrap(b_wrap),
    .onehot(b_onehot), .err_count(b_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: m_run = -1 while searching, else good steps seen since the anchoring 0.
  int m_run, m_prev, m_errs, m_onehot;
  bit m_locked, m_err, m_wrap;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_reset();
    m_run = -1; m_prev = 0; m_errs = 0; m_onehot = 0;
    m_locked = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_step(input int v);
    bit good, was_locked;
    good       = (v == (m_prev + 1) % N);
    was_locked = (m_run >= LC);
    m_err  = 0;
    m_wrap = 0;
    if (v >= N) begin
      m_err = 1; m_run = -1;
    end else if (m_run < 0) begin
      m_run = (v == 0) ? 0 : -1;
    end else if (good) begin
      if (m_run < LC) m_run++;
      m_wrap = was_locked && (v == 0);
    end else if (was_locked) begin
      m_err = 1; m_run = -1;
    end else begin
      m_run = (v == 0) ? 0 : -1;
    end
    m_locked = (m_run >= LC);
    m_onehot = (v < N) ? (1 << v) : 0;
    m_errs  += m_err;
    m_prev   = v;
  endtask

  task automatic compare_all();
    chk("locked_a", a_locked, m_locked);
    chk("err_a", a_err, m_err);
    chk("wrap_a", a_wrap, m_wrap);
    chk("onehot_a", a_onehot, m_onehot);
    chk("errcnt_a", a_cnt, ECNT_ON * sat(m_errs, 8));
    chk("locked_b", b_locked, m_locked);
    chk("err_b", b_err, m_err);
    chk("wrap_b", b_wrap, m_wrap);
    chk("errcnt_b", b_cnt, ECNT_ON * sat(m_errs, 2));
    chk("err_wrap_excl", a_err & a_wrap, 0);
  endtask

  task automatic step(input int v);
    @(negedge clk);
    reset = 1'b0;
    {q2, q1, q0} = 3'(v);
    @(posedge clk);
    model_step(v);
    #1 compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, a_locked | b_locked, 0);
    chk({tag, "_err"}, a_err | b_err, 0);
    chk({tag, "_wrap"}, a_wrap | b_wrap, 0);
    chk({tag, "_onehot"}, a_onehot | b_onehot, 0);
    chk({tag, "_errcnt"}, a_cnt | 8'(b_cnt), 0);
  endtask

  // Called just after a step's compare; asserts reset mid-cycle, checks before any edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
  endtask

  initial begin
    int v, last_v, cnt, r;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");

    // Clean counter: lock two samples after the first 0, wrap on 4->0.
    step(0); chk("lock_t0", a_locked, 0);
    step(1); chk("lock_t1", a_locked, 0);
    step(2); chk("lock_t2", a_locked, 1);
    step(3); step(4);
    step(0); chk("wrap_lit", a_wrap, 1); chk("onehot_lit0", a_onehot, 1);
    step(1); chk("wrap_once", a_wrap, 0);

    // Skip 1 -> 3 while locked.
    step(3); chk("skip_err", a_err, 1); chk("skip_unlock", a_locked, 0);
    chk("skip_cnt", a_cnt, ECNT_ON);
    step(4); chk("skip_err_once", a_err, 0);
    step(0); step(1); step(2); chk("relock", a_locked, 1);

    // Stall on 2.
    step(2); chk("stall_err", a_err, 1); chk("stall_unlock", a_locked, 0);
    chk("stall_cnt", a_cnt, ECNT_ON * 2);

    // Out-of-range in ACQUIRE, then held counter reset.
    step(0);
    step(6); chk("oor_err", a_err, 1); chk("oor_onehot", a_onehot, 0);
    step(0); chk("acq_after_oor", a_err, 0);
    repeat (4) step(0);
    step(1); chk("onehot_lit1", a_onehot, 5'b00010);
    step(2); chk("lock_after_hold", a_locked, 1);

    // Five more errors: ERRW=2 instance saturates, err keeps pulsing.
    repeat (5) step(7);
    chk("sat_b", b_cnt, ECNT_ON * 3);
    chk("sat_err_pulse", b_err, 1);
    chk("cnt_a_8", a_cnt, ECNT_ON * 8);

    step(0); step(1); step(2); step(3);
    chk("lock_before_rst", a_locked, 1);
    async_reset();
    step(0); step(1); step(2); chk("relock_after_rst", a_locked, 1);

    // Randomised counter with skips, stalls, bad codes, counter resets, async resets.
    cnt = 3; last_v = 2;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 88) begin
        v = cnt; cnt = (cnt + 1) % N;
      end else if (r < 92) begin
        v = $urandom_range(0, 7);
      end else if (r < 96) begin
        v = last_v;
      end else begin
        v = 0; cnt = 1;
      end
      step(v);
      last_v = v;
      if ($urandom_range(0, 249) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Sequence checker for the mod-N counter's Q2..Q0 outputs. It samples the 3-bit count on the rising edge, midway between the counter's falling-edge updates. It confirms the count steps 0,1,…,N-1,0 every cycle and declares lock once the sequence is confirmed. It also flags skips, stalls and out-of-range codes, and emits a one-hot decode plus a wrap pulse for downstream timing logic.

## Interface
- N, 5: modulus of the observed counter; legal range 2..8.
- LOCK_CNT, 2: number of consecutive correct steps after seeing 0 that are required to assert lock; range 1..15.
- ERRW, 8: width of the error counter.
- clk  in  1  clock; inputs are sampled on posedge.
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately.
- Q0, Q1, Q2  in  1 each  observed count bits; v = {Q2,Q1,Q0}.
- locked  out  1  sequence locked.
- err  out  1  one-cycle pulse on any detected violation.
- wrap  out  1  one-cycle pulse when a locked N-1→0 step is seen.
- onehot  out  N  registered one-hot decode of v; all zero when v ≥ N.
- err_count  out  ERRW  saturating count of err pulses.

## Operation
- Each posedge registers v as prev, compares it with the previous sample, and updates the FSM. All outputs are registered at the same edge.
- Expected next value is exp = (prev == N-1) ? 0 : prev+1. A step is good when v == exp.
- The FSM has three states, SEARCH, ACQUIRE and LOCKED, and resets to SEARCH.
  - SEARCH → ACQUIRE when v == 0. The good-step counter gcnt clears to 0.
  - ACQUIRE, good step: gcnt++. When gcnt reaches LOCK_CNT → LOCKED.
  - ACQUIRE, v == 0 held or any bad in-range step: stay in ACQUIRE if v == 0 with gcnt=0, otherwise go to SEARCH. No err pulse.
  - LOCKED, good step: stay. If the step is N-1→0, wrap=1.
  - LOCKED, bad step (skip, stall, or a premature 0 from counter reset): err=1 and → SEARCH. locked drops at that same edge.
- An out-of-range code (v ≥ N) in any state gives err=1 and → SEARCH, and onehot is all zeros.
- err_count increments on each err and saturates at 2^ERRW-1. It has no wrap.
- onehot[v] = 1 for v < N in every state.

## Timing
- Reset values: locked=0, err=0, wrap=0, onehot=0, err_count=0, state=SEARCH, prev=0, gcnt=0.
- Latency: an input sampled at posedge t is reflected in all outputs after posedge t. err and wrap are high for exactly one cycle.
- With a clean counter starting at 0 at sample t0, locked rises at sample t0+LOCK_CNT.
- Asserting reset mid-lock clears all outputs asynchronously. After release, the monitor re-acquires from SEARCH.
- Simultaneous conditions:
  - Out-of-range takes priority over step checking.
  - err and wrap are never both high.
  - err_count saturation holds its value, and err still pulses.

## Configuration
- COUNTER_MONITOR_ERRCNT_EN
  - Defined: the err_count register and saturation logic are present as described.
  - Undefined: err_count is tied to 0 and no counter flops are inferred. err, locked, wrap and onehot are unchanged.

## Structure
- Package counter_monitor_pkg holds:
  - the state enum {SEARCH, ACQUIRE, LOCKED};
  - the 3-bit code width constant;
  - a next_count(prev, N) function.
- One sub-module, counter_monitor_decode: a combinational v → one-hot[N] decode with the range flag. It is instantiated once, and the top module registers its outputs.

## Test plan
- Reset release with a clean mod-5 counter 0,1,2,3,4,0… → locked rises 2 cycles after the first 0 sample; wrap pulses on each 4→0; err never fires; err_count=0.
- Once locked, force the sequence 0,1,3 → err=1 for one cycle at the sample of 3; locked=0; err_count=1; state SEARCH. Re-lock after the next 0 plus 2 good steps.
- Once locked, hold v=2 for two samples (stall) → err pulse; locked drops; err_count increments by 1.
- Inject v=6 while in ACQUIRE → err=1, onehot=0, return to SEARCH; sample 0 next → ACQUIRE.
- Counter reset held for 4 cycles (v=0 repeated) while in ACQUIRE → no err, stays in ACQUIRE; after release, 0,1,2 → locked.
- With ERRW=2, generate 5 errors → err_count saturates at 3 and err still pulses. Assert reset mid-run → all outputs are 0 immediately, before the next clk edge.
